// File: rtl/restador_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package restador_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int unsigned WIDTH_DEF = 4;
   localparam int unsigned DIGIT_DEF = 2;

   // Counter is one bit wider than needed so NDIG itself is representable.
   function automatic int unsigned cnt_width(input int unsigned ndig);
      return $clog2(ndig) + 1;
   endfunction

endpackage

// File: rtl/restador_digito.sv
// Combinational DIGIT-bit ripple-borrow slice: diff = a - b - borrow_in.
module restador_digito
   import restador_pkg::*;
#(
   parameter int unsigned DIGIT = DIGIT_DEF
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   input  logic             borrow_i,
   output logic [DIGIT-1:0] diff_c,
   output logic             borrow_c
);

   logic [DIGIT:0] full_c;

   // One extra bit catches the borrow as the sign of the slice result.
   always_comb begin
      full_c   = {1'b0, a_i} - {1'b0, b_i} - (DIGIT+1)'(borrow_i);
      diff_c   = full_c[DIGIT-1:0];
      borrow_c = full_c[DIGIT];
   end

endmodule

// File: rtl/restador_serial.sv
// Digit-serial subtractor D = A - B - BIN, LSB digit first, start/busy/done handshake.
module restador_serial
   import restador_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DIGIT = DIGIT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             BIN,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             BOUT,
   output logic             V,
   output logic             Z
);

   localparam int unsigned NDIG  = WIDTH / DIGIT;
   localparam int unsigned CNT_W = cnt_width(NDIG);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, work_q, work_d, d_q, d_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               borrow_q, borrow_d;
   logic               a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               bout_q, bout_d, v_q, v_d, z_q, z_d;
   logic [DIGIT-1:0]   slice_diff_c;
   logic               slice_borrow_c;

   restador_digito #(.DIGIT(DIGIT)) u_digito (
      .a_i      (a_q[DIGIT-1:0]),
      .b_i      (b_q[DIGIT-1:0]),
      .borrow_i (borrow_q),
      .diff_c   (slice_diff_c),
      .borrow_c (slice_borrow_c)
   );

   // Next-state, datapath and result update.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      d_d      = d_q;
      bout_d   = bout_q;
      v_d      = v_q;
      z_d      = z_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d      = A;
               b_d      = B;
               borrow_d = BIN;
               a_msb_d  = A[WIDTH-1];
               b_msb_d  = B[WIDTH-1];
               work_d   = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d      = a_q >> DIGIT;
            b_d      = b_q >> DIGIT;
            work_d   = WIDTH'({slice_diff_c, work_q} >> DIGIT);
            borrow_d = slice_borrow_c;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NDIG - 1)) begin
               d_d     = work_d;
               bout_d  = slice_borrow_c;
               v_d     = (a_msb_q != b_msb_q) && (work_d[WIDTH-1] != a_msb_q);
               z_d     = (work_d == '0);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         d_q      <= '0;
         bout_q   <= 1'b0;
         v_q      <= 1'b0;
         z_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         d_q      <= d_d;
         bout_q   <= bout_d;
         v_q      <= v_d;
         z_q      <= z_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign D    = d_q;
   assign BOUT = bout_q;
   assign V    = v_q;
   assign Z    = z_q;

endmodule

// File: tb/tb_restador_serial.sv
// Scoreboard bench for restador_serial (WIDTH=4, DIGIT=2).
module tb_restador_serial;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DIGIT = 2;
   localparam int unsigned NDIG  = WIDTH / DIGIT;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             bout;
      logic             v;
      logic             z;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic             BIN = 1'b0;
   logic             busy, done, BOUT, V, Z;
   logic [WIDTH-1:0] D;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_done   = 0;

   restador_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .BIN   (BIN),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .BOUT  (BOUT),
      .V     (V),
      .Z     (Z)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic bin);
      exp_t             e;
      logic [WIDTH:0]   full;
      full   = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bin);
      e.d    = full[WIDTH-1:0];
      e.bout = full[WIDTH];
      e.v    = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
      e.z    = (e.d == '0);
      return e;
   endfunction

   // Result monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         n_done++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("D", 32'(D), 32'(e.d));
            check("BOUT", 32'(BOUT), 32'(e.bout));
            check("V", 32'(V), 32'(e.v));
            check("Z", 32'(Z), 32'(e.z));
         end
      end
   end

   // Single op with exact latency and busy-window checks.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
      @(negedge clk);
      A = a; B = b; BIN = bin; start = 1'b1;
      exp_q.push_back(model(a, b, bin));
      @(posedge clk); #1;
      start = 1'b0;
      A = ~a; B = ~b; BIN = ~bin;
      for (int k = 1; k < int'(NDIG); k++) begin
         check("busy_mid", 32'(busy), 32'd1);
         check("done_mid", 32'(done), 32'd0);
         @(posedge clk); #1;
      end
      check("busy_mid", 32'(busy), 32'd1);
      check("done_mid", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("done_pulse", 32'(done), 32'd1);
      check("busy_end", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while ((busy || exp_q.size() != 0) && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check("wait_timeout", 32'(k < budget), 32'd1);
   endtask

   initial begin
      int dones_before;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_D", 32'(D), 32'd0);
      check("rst_flags", 32'({BOUT, V, Z}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(4'd7, 4'd4, 1'b0);
      run_op(4'd3, 4'd5, 1'b0);
      run_op(4'd8, 4'd1, 1'b0);
      run_op(4'd5, 4'd5, 1'b0);
      run_op(4'd0, 4'd0, 1'b1);
      run_op(4'd6, 4'd1, 1'b1);
      run_op(4'd2, 4'd9, 1'b1);

      // Start while busy is ignored; start held through done cycle is accepted.
      dones_before = n_done;
      @(negedge clk);
      A = 4'd2; B = 4'd1; BIN = 1'b0; start = 1'b1;
      exp_q.push_back(model(4'd2, 4'd1, 1'b0));
      @(negedge clk);
      A = 4'd1; B = 4'd0; BIN = 1'b0;
      @(negedge clk);
      A = 4'd9; B = 4'd3; BIN = 1'b1;
      exp_q.push_back(model(4'd9, 4'd3, 1'b1));
      @(posedge clk); #1;
      check("done_first", 32'(done), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy", 32'(busy), 32'd1);
      wait_idle(20);
      check("b2b_done_count", 32'(n_done - dones_before), 32'd2);

      // Asynchronous reset mid-operation aborts without a done pulse.
      dones_before = n_done;
      @(negedge clk);
      A = 4'd12; B = 4'd3; BIN = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_D", 32'(D), 32'd0);
      check("abort_flags", 32'({done, BOUT, V, Z}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", 32'(n_done - dones_before), 32'd0);
      run_op(4'd12, 4'd3, 1'b0);

      for (int i = 0; i < 12; i++) begin
         run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      wait_idle(20);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
